// File: rtl/enc_share_arbiter_if.sv
// Requester/consumer bus for the shared 3-to-7 encoder arbiter.
// The master side drives the requests and out_ready; the slave side is the arbiter.
interface enc_share_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CODE_W = 7;

    logic [N_REQ-1:0]      req_valid;
    logic [OP_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]      req_mode;
    logic [N_REQ-1:0]      req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [CODE_W-1:0]     out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_mode;

    modport master (
        output req_valid, req_data, req_mode, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_mode
    );

    modport slave (
        input  req_valid, req_data, req_mode, out_ready,
        output req_ready, out_valid, out_data, out_id, out_mode
    );
endinterface

// File: rtl/enc_share_arbiter.sv
// Round-robin arbiter sharing one Gray/one-hot-table 3-to-7 encoder among N_REQ requesters.
// One result is held in an output register under valid/ready backpressure, tagged with its requester.
module enc_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    enc_share_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [7:0]           grant_count
);
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RESULT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   idx;
    logic              grant_found;
    logic              accept;
    logic              handoff;
    logic [OP_W-1:0]   ops [N_REQ];
    logic [OP_W-1:0]   sel_op;
    logic              sel_mode;

    function automatic logic [CODE_W-1:0] encode(input logic [OP_W-1:0] a, input logic gray);
        logic [CODE_W-1:0] code;
        if (gray) begin
            code = {4'b0000, a[2], a[2] ^ a[1], a[1] ^ a[0]};
        end else if (a == '0) begin
            code = '0;
        end else begin
            code = CODE_W'(1) << (a - OP_W'(1));
        end
        return code;
    endfunction

    // First pending requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ops[i] = bus.req_data[OP_W*i +: OP_W];
        end
        sel_op   = ops[grant_idx];
        sel_mode = bus.req_mode[grant_idx];
    end

    assign rr_next = (bus.out_id == ID_W'(N_REQ - 1)) ? '0 : bus.out_id + ID_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable && grant_found) state_d = S_RESULT;
            S_RESULT: if (bus.out_ready)         state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; req_ready is the accept strobe and the only input-to-output path
    always_comb begin
        accept        = 1'b0;
        handoff       = 1'b0;
        bus.req_ready = '0;
        busy          = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = !rst && enable && grant_found;
                if (accept) bus.req_ready = N_REQ'(1) << grant_idx;
            end
            S_RESULT: begin
                busy    = 1'b1;
                handoff = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Result register, round-robin pointer and accept counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            bus.out_mode  <= 1'b0;
            grant_count   <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= encode(sel_op, sel_mode);
            bus.out_id    <= grant_idx;
            bus.out_mode  <= sel_mode;
            grant_count   <= grant_count + CNT_W'(1);
        end else if (handoff) begin
            bus.out_valid <= 1'b0;
            rr_ptr_q      <= rr_next;
        end
    end
endmodule

// File: tb/tb_enc_share_arbiter.sv
// Directed bench for enc_share_arbiter: encoding, round-robin order, backpressure, enable and reset.
module tb_enc_share_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       busy;
    logic [7:0] grant_count;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [6:0] exp_data [4];

    enc_share_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    enc_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_data[0] = 7'h01;
        exp_data[1] = 7'h02;
        exp_data[2] = 7'h02;
        exp_data[3] = 7'h08;

        rst           = 1'b1;
        enable        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_mode  = '0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_id",    32'(bus.out_id),    32'd0);
        chk("rst_out_mode",  32'(bus.out_mode),  32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_gcount",    32'(grant_count),   32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Gray, requester 0, operand 101
        bus.req_valid = 4'b0001;
        bus.req_data  = 12'b000_000_000_101;
        bus.req_mode  = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_req_ready", 32'(bus.req_ready), 32'b0001);
        tick;
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_data",  32'(bus.out_data),  32'b0000111);
        chk("t1_out_id",    32'(bus.out_id),    32'd0);
        chk("t1_out_mode",  32'(bus.out_mode),  32'd1);
        chk("t1_gcount",    32'(grant_count),   32'd1);
        chk("t1_busy",      32'(busy),          32'd1);
        chk("t1_ready_res", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        tick;
        chk("t1_handoff_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_handoff_busy",  32'(busy),          32'd0);

        // Table, requester 2, operand 110
        bus.req_valid = 4'b0100;
        bus.req_data  = 12'b000_110_000_000;
        bus.req_mode  = 4'b0000;
        #1;
        chk("t2_req_ready", 32'(bus.req_ready), 32'b0100);
        tick;
        chk("t2_out_data", 32'(bus.out_data), 32'b0100000);
        chk("t2_out_id",   32'(bus.out_id),   32'd2);
        chk("t2_out_mode", 32'(bus.out_mode), 32'd0);
        chk("t2_gcount",   32'(grant_count),  32'd2);
        bus.req_valid = '0;
        tick;

        // Operand 000 in Gray mode (requester 3), then table mode (requester 0)
        bus.req_valid = 4'b1000;
        bus.req_data  = '0;
        bus.req_mode  = 4'b1000;
        #1;
        chk("t3g_req_ready", 32'(bus.req_ready), 32'b1000);
        tick;
        chk("t3g_out_data", 32'(bus.out_data), 32'd0);
        chk("t3g_out_mode", 32'(bus.out_mode), 32'd1);
        chk("t3g_out_id",   32'(bus.out_id),   32'd3);
        bus.req_valid = '0;
        tick;
        bus.req_valid = 4'b0001;
        bus.req_mode  = 4'b0000;
        #1;
        chk("t3t_req_ready", 32'(bus.req_ready), 32'b0001);
        tick;
        chk("t3t_out_data", 32'(bus.out_data), 32'd0);
        chk("t3t_out_mode", 32'(bus.out_mode), 32'd0);
        chk("t3t_out_id",   32'(bus.out_id),   32'd0);
        chk("t3t_gcount",   32'(grant_count),  32'd4);
        bus.req_valid = '0;
        tick;

        // Round robin with all four requesting, after a fresh reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rr_gcount_rst", 32'(grant_count), 32'd0);
        bus.req_valid = 4'b1111;
        bus.req_data  = 12'b100_011_010_001;
        bus.req_mode  = 4'b0101;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_req_ready", 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
            tick;
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_out_id",    32'(bus.out_id),    32'(i % 4));
            chk("rr_out_data",  32'(bus.out_data),  32'(exp_data[i % 4]));
            chk("rr_ready_res", 32'(bus.req_ready), 32'd0);
            chk("rr_busy",      32'(busy),          32'd1);
            tick;
            chk("rr_handoff",   32'(bus.out_valid), 32'd0);
        end
        chk("rr_gcount", 32'(grant_count), 32'd8);

        // Backpressure: Gray 111 from requester 1 held for 5 cycles
        bus.req_valid = 4'b0010;
        bus.req_data  = 12'b000_000_111_000;
        bus.req_mode  = 4'b0010;
        bus.out_ready = 1'b0;
        #1;
        chk("bp_req_ready", 32'(bus.req_ready), 32'b0010);
        tick;
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_out_data",  32'(bus.out_data),  32'h04);
        chk("bp_out_id",    32'(bus.out_id),    32'd1);
        bus.req_valid = 4'b1111;
        bus.req_data  = 12'b111_111_000_111;
        repeat (5) begin
            tick;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data",  32'(bus.out_data),  32'h04);
            chk("bp_hold_id",    32'(bus.out_id),    32'd1);
            chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_hold_busy",  32'(busy),          32'd1);
        end
        bus.out_ready = 1'b1;
        enable        = 1'b0;
        tick;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_busy",  32'(busy),          32'd0);
        chk("bp_gcount",        32'(grant_count),   32'd9);

        // enable low: all requesting, no grants
        repeat (10) begin
            chk("en_req_ready", 32'(bus.req_ready), 32'd0);
            chk("en_out_valid", 32'(bus.out_valid), 32'd0);
            tick;
        end
        chk("en_gcount", 32'(grant_count), 32'd9);

        // Reset while a result is pending
        enable        = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("mr_req_ready", 32'(bus.req_ready), 32'b0100);
        tick;
        chk("mr_out_id",    32'(bus.out_id),    32'd2);
        chk("mr_out_valid", 32'(bus.out_valid), 32'd1);
        chk("mr_gcount",    32'(grant_count),   32'd10);
        tick;
        rst = 1'b1;
        tick;
        chk("mr_rst_valid",  32'(bus.out_valid), 32'd0);
        chk("mr_rst_gcount", 32'(grant_count),   32'd0);
        chk("mr_rst_busy",   32'(busy),          32'd0);
        rst = 1'b0;
        #1;
        chk("mr_regrant_ready", 32'(bus.req_ready), 32'b0001);
        tick;
        chk("mr_regrant_id",     32'(bus.out_id),  32'd0);
        chk("mr_regrant_gcount", 32'(grant_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/enc_share_arbiter.md
Name: enc_share_arbiter

Overview:
- Shares one 3-to-7 code encoder between N_REQ requesters using a round-robin arbiter.
- Each requester submits a 3-bit value and a per-request mode bit: Gray or sparse one-hot table.
- The block grants one requester, captures its operands and encodes them into an output register.
- It holds the result under valid/ready backpressure and tags it with the requester ID.
- It sits between the front-end request sources and the downstream consumer of encoded codes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of out_id; must equal clog2(N_REQ).

Ports:
- clk, input, 1, single system clock; all state changes on rising edge.
- rst, input, 1, reset, synchronous and active-high.
- enable, input, 1, when low no new grants are issued; an in-flight result still completes.
- req_valid, input, N_REQ, per-requester request pending.
- req_data, input, 3*N_REQ, requester i operand at bits [3i+2:3i].
- req_mode, input, N_REQ, per-requester mode: 1 = Gray, 0 = table.
- req_ready, output, N_REQ, one-hot grant/accept strobe; at most one bit high.
- out_valid, output, 1, encoded result available.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, 7, encoded result.
- out_id, output, ID_W, index of the requester that produced out_data.
- out_mode, output, 1, mode used for out_data.
- busy, output, 1, high in RESULT state.
- grant_count, output, 8, total accepted requests; wraps 255 -> 0.

Behaviour:
- Encoding, Gray mode (A = captured operand):
  - B[6:3] = 0
  - B[2] = A2
  - B[1] = A2^A1
  - B[0] = A1^A0
- Encoding, table mode: A=0 -> 7'b0000000; A=k for k=1..7 -> 7'b1 << (k-1).
- FSM, 2 states:
  - IDLE, reset state.
  - RESULT.
- IDLE behaviour:
  - When enable=1 and any req_valid bit is set, grant g = first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in that same cycle; this is the accept.
  - On that edge: capture the encoded value of req_data[g]/req_mode[g] into out_data, set out_id=g, out_mode=req_mode[g], out_valid=1, grant_count+1; go to RESULT.
  - Latency: accept at edge t, out_valid high after edge t (visible in cycle t+1).
- RESULT behaviour:
  - req_ready is all zero.
  - out_data, out_id and out_mode are held stable while out_valid=1 and out_ready=0.
  - On the edge with out_ready=1: out_valid<=0, rr_ptr <= (out_id+1) mod N_REQ, go to IDLE.
  - Maximum throughput is one result per 2 cycles.
- Arbitration rules:
  - rr_ptr advances only on result handoff, never on accept.
  - A requester that is just served has the lowest priority on the next arbitration.
  - req_valid changes during RESULT are ignored.
  - Operands are sampled only at accept.
  - Requesters must not make req_valid depend on req_ready.
- enable=0:
  - In IDLE: no grant, req_ready=0.
  - In RESULT: the pending result still hands off normally.
- out_ready high while out_valid=0 is ignored.
- Reset values:
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_id=0, out_mode=0, req_ready=0, busy=0, grant_count=0.
- Reset mid-operation:
  - A pending result is discarded at the reset edge; no handoff occurs.
  - rr_ptr returns to 0.
- busy = (state==RESULT).
- No other combinational paths from inputs to outputs; req_ready is the only combinational output.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[2:0]=3'b101, req_mode[0]=1, out_ready=1:
  - req_ready=0001 in the accept cycle.
  - Next cycle out_valid=1, out_data=7'b0000111, out_id=0, grant_count=1.
- Table mode, requester 2, data=3'b110:
  - out_data=7'b0100000, out_id=2, out_mode=0.
- Data=3'b000 in each mode -> out_data=7'b0000000 in both.
- All four req_valid held high, out_ready=1, 8 handoffs:
  - Grant order 0,1,2,3,0,1,2,3.
  - No req_ready in RESULT cycles.
  - grant_count=8.
- Backpressure, out_ready=0 for 5 cycles after the result:
  - out_valid, out_data and out_id stay constant; req_ready stays 0; busy=1.
  - Raise out_ready -> handoff; IDLE next cycle.
- enable=0 with req_valid=1111 -> no grants for 10 cycles.
- rst asserted while in RESULT with out_ready=0:
  - The next cycle shows out_valid=0, grant_count=0.
  - The next grant with all requests pending goes to requester 0.
